// File: rtl/compare.sv
// Registered 2-bit unsigned magnitude comparator.
// It drives one-hot lt/gt/eq flags one clock after the operands are sampled.
module compare (
   input  logic A1,
   input  logic A0,
   input  logic B1,
   input  logic B0,
   output logic lt,
   output logic gt,
   output logic eq,
   input  logic clk,
   input  logic rst
);

   logic lt_n;
   logic gt_n;
   logic eq_n;
   logic msb_same;

   // The MSB decides the result unless both MSBs match; only then does the LSB matter.
   // Plain gate equations are used so that an X on any operand bit reaches the flags.
   always_comb begin
      msb_same = ~(A1 ^ B1);
      gt_n     = (A1 & ~B1) | (msb_same & A0 & ~B0);
      lt_n     = (~A1 & B1) | (msb_same & ~A0 & B0);
      eq_n     = msb_same & ~(A0 ^ B0);
   end

   // NOTE: sequential state uses non-blocking assignments so that every flag
   // samples the same pre-edge values. Reset gives 000, the "no result" state.
   always_ff @(posedge clk) begin
      if (rst) begin
         lt <= 1'b0;
         gt <= 1'b0;
         eq <= 1'b0;
      end else begin
         lt <= lt_n;
         gt <= gt_n;
         eq <= eq_n;
      end
   end

endmodule

// File: tb/tb_compare.sv
// Self-checking bench for compare: directed reset/compare steps followed by an
// exhaustive sweep and a random run, all checked against an arithmetic model.
module tb_compare;

   logic clk;
   logic rst;
   logic A1, A0, B1, B0;
   logic lt, gt, eq;

   int n_cmp = 0;
   int n_err = 0;

   compare dut (
      .A1 (A1),
      .A0 (A0),
      .B1 (B1),
      .B0 (B0),
      .lt (lt),
      .gt (gt),
      .eq (eq),
      .clk(clk),
      .rst(rst)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   // Reference model: plain unsigned integer comparison, or 000 under reset.
   function automatic logic [2:0] model(input int a, input int b, input logic r);
      if (r) return 3'b000;
      return {a < b, a > b, a == b};
   endfunction

   task automatic check(input string tag, input logic [2:0] obs, input logic [2:0] exp);
      n_cmp++;
      assert (obs === exp)
      else begin
         n_err++;
         $error("FAIL %s observed=%b expected=%b", tag, obs, exp);
      end
   endtask

   // Drive operands and reset, take one edge, sample away from the edge, check.
   task automatic step(input string tag, input int a, input int b, input logic r);
      logic [1:0] av;
      logic [1:0] bv;
      av  = 2'(a);
      bv  = 2'(b);
      A1  = av[1];
      A0  = av[0];
      B1  = bv[1];
      B0  = bv[0];
      rst = r;
      @(posedge clk);
      #1;
      check(tag, {lt, gt, eq}, model(a, b, r));
      if (!r) check({tag, "_onehot"}, {2'b00, $onehot({lt, gt, eq})}, 3'b001);
   endtask

   initial begin
      logic [2:0] held;
      int a;
      int b;
      logic r;

      rst = 1'b1;
      {A1, A0, B1, B0} = 4'b0000;
      @(negedge clk);

      // Reset with A=11, B=00 for two edges, then release.
      step("reset0", 3, 0, 1'b1);
      step("reset1", 3, 0, 1'b1);
      step("reset_release_gt", 3, 0, 1'b0);

      step("lt_00_10", 0, 2, 1'b0);
      step("gt_11_10", 3, 2, 1'b0);
      step("eq_01_01", 1, 1, 1'b0);
      step("msb_gt_10_01", 2, 1, 1'b0);
      step("msb_lt_01_10", 1, 2, 1'b0);

      // Changing operands between edges must not disturb the registered flags.
      held = {lt, gt, eq};
      {A1, A0, B1, B0} = 4'b1100;
      #3;
      check("between_edges_hold", {lt, gt, eq}, held);

      // Exhaustive sweep on consecutive cycles.
      for (int i = 0; i < 16; i++) begin
         step($sformatf("exh_a%0d_b%0d", i / 4, i % 4), i / 4, i % 4, 1'b0);
      end

      // Mid-stream reset on A=01, B=11, then release.
      step("midrst_assert", 1, 3, 1'b1);
      step("midrst_release_lt", 1, 3, 1'b0);

      // Random run with occasional reset pulses.
      for (int i = 0; i < 60; i++) begin
         a = int'($urandom_range(3, 0));
         b = int'($urandom_range(3, 0));
         r = ($urandom_range(7, 0) == 0);
         step($sformatf("rnd%0d_a%0d_b%0d_r%0d", i, a, b, r), a, b, r);
      end

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
      $finish;
   end

endmodule
